// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared encodings for the memory pipeline stage: access-size codes,
// writeback-source codes, the access FSM state encoding, and the
// alignment rule used both at the latch edge and inside mem_align.
//
// Bit numbering note: the architecture numbers bits big-endian
// (bit 0 = MSB). Vectors in this slice are declared descending, so
// architectural bit i is vector bit 31-i; e.g. addr[30:31] is addr[1:0]
// here, and byte lane 0 (bits [0:7]) is data[31:24].
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MS_BYTE     = 2'b00,
        MS_HALF     = 2'b01,
        MS_WORD     = 2'b10,
        MS_WORD_ALT = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        DS_ALU = 2'b00,
        DS_MEM = 2'b01,
        DS_PC4 = 2'b10,
        DS_FPU = 2'b11
    } din_src_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Half accesses need an even byte offset; word accesses (and the
    // spare size code, which behaves as word) need offset 0.
    function automatic logic is_misaligned(input logic [1:0] offset,
                                           input logic [1:0] size);
        logic mis;
        case (size)
            MS_BYTE: mis = 1'b0;
            MS_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align
// Combinational big-endian lane steering for the memory stage.
// Ports:
//   offset     in  2   byte offset within the word (architectural addr[30:31])
//   size       in  2   access size code (mem_size_e)
//   ext        in  1   1 = sign-extend loads, 0 = zero-extend
//   store_data in  32  register value to be stored
//   read_word  in  32  word returned by data memory
//   wdata      out 32  store data replicated across all candidate lanes
//   byte_en    out 4   store lane enables, bit 3 = most significant lane
//   load_value out 32  extracted, right-justified, extended load value
//   misaligned out 1   access violates its natural alignment
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        ext,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane 0 is the most significant byte, so offset 0 selects [31:24]
    // and the byte enable pattern walks from bit 3 downwards.
    always_comb begin
        wdata      = store_data;
        byte_en    = 4'b1111;
        load_value = read_word;
        lane_byte  = 8'h00;
        lane_half  = offset[1] ? read_word[15:0] : read_word[31:16];

        case (offset)
            2'd0:    lane_byte = read_word[31:24];
            2'd1:    lane_byte = read_word[23:16];
            2'd2:    lane_byte = read_word[15:8];
            default: lane_byte = read_word[7:0];
        endcase

        case (size)
            MS_BYTE: begin
                wdata      = {4{store_data[7:0]}};
                byte_en    = 4'b1000 >> offset;
                load_value = {{24{ext & lane_byte[7]}}, lane_byte};
            end
            MS_HALF: begin
                wdata      = {2{store_data[15:0]}};
                byte_en    = offset[1] ? 4'b0011 : 4'b1100;
                load_value = {{16{ext & lane_half[15]}}, lane_half};
            end
            default: begin
                wdata      = store_data;
                byte_en    = 4'b1111;
                load_value = read_word;
            end
        endcase

        misaligned = is_misaligned(offset, size);
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Pipeline stage after execute: registers execute results, performs
// data-memory loads/stores over a req/ack handshake, and hands results
// to writeback and back to execute via the MemData forwarding bus.
// Ports:
//   clk, reset                    clock, async active-high reset
//   Next*                         execute-stage results and control
//   DmemReq/WE/Addr/WData/ByteEn  data-memory request side
//   DmemAck/RData                 data-memory response side
//   MemStall                      freezes this and upstream stages
//   MemData                       forwarding value selected by DInSrc
//   DInSrc/RegWE/RegWAddr         writeback control (RegWE gated)
//   ALUOut/FPUOut/PCPlusFour/LoadData  writeback operands
//   Misaligned                    current instruction was misaligned
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   NextALUOut,
    input  logic [31:0]   NextFPUOut,
    input  logic [31:0]   NextRegB,
    input  logic [31:0]   NextPCPlusFour,
    input  logic [1:0]    NextDInSrc,
    input  logic          NextRegWE,
    input  logic [5:0]    NextRegWAddr,
    input  logic [1:0]    NextMEMSize,
    input  logic          NextMEMWE,
    input  logic          NextExtMEM,
    output logic          DmemReq,
    output logic          DmemWE,
    output logic [AW-1:0] DmemAddr,
    output logic [31:0]   DmemWData,
    output logic [3:0]    DmemByteEn,
    input  logic          DmemAck,
    input  logic [31:0]   DmemRData,
    output logic          MemStall,
    output logic [31:0]   MemData,
    output logic [1:0]    DInSrc,
    output logic          RegWE,
    output logic [5:0]    RegWAddr,
    output logic [31:0]   ALUOut,
    output logic [31:0]   FPUOut,
    output logic [31:0]   PCPlusFour,
    output logic [31:0]   LoadData,
    output logic          Misaligned
);

    logic [31:0] alu_q;
    logic [31:0] fpu_q;
    logic [31:0] regb_q;
    logic [31:0] pc4_q;
    logic [1:0]  din_src_q;
    logic        reg_we_q;
    logic [5:0]  reg_waddr_q;
    logic [1:0]  mem_size_q;
    logic        mem_we_q;
    logic        ext_q;
    logic [31:0] load_data_q;

    state_e state;
    state_e state_next;

    logic        next_mem_op;
    logic        next_misaligned;
    logic        mem_op_q;
    logic        is_load_q;

    logic [31:0] align_wdata;
    logic [3:0]  align_byte_en;
    logic [31:0] align_load;
    logic        align_misaligned;

    // The decision to start an access is made from the incoming
    // instruction, since the FSM moves to REQ on the same edge that
    // latches it.
    assign next_mem_op     = NextMEMWE | (NextDInSrc == DS_MEM);
    assign next_misaligned = is_misaligned(NextALUOut[1:0], NextMEMSize);

    assign is_load_q = (din_src_q == DS_MEM);
    assign mem_op_q  = mem_we_q | is_load_q;

    mem_align u_align (
        .offset     (alu_q[1:0]),
        .size       (mem_size_q),
        .ext        (ext_q),
        .store_data (regb_q),
        .read_word  (DmemRData),
        .wdata      (align_wdata),
        .byte_en    (align_byte_en),
        .load_value (align_load),
        .misaligned (align_misaligned)
    );

    // Pipeline register. It holds for as long as an access is
    // outstanding (state REQ), which is exactly when MemStall is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q       <= '0;
            fpu_q       <= '0;
            regb_q      <= '0;
            pc4_q       <= '0;
            din_src_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            mem_size_q  <= '0;
            mem_we_q    <= 1'b0;
            ext_q       <= 1'b0;
        end else if (state != REQ) begin
            alu_q       <= NextALUOut;
            fpu_q       <= NextFPUOut;
            regb_q      <= NextRegB;
            pc4_q       <= NextPCPlusFour;
            din_src_q   <= NextDInSrc;
            reg_we_q    <= NextRegWE;
            reg_waddr_q <= NextRegWAddr;
            mem_size_q  <= NextMEMSize;
            mem_we_q    <= NextMEMWE;
            ext_q       <= NextExtMEM;
        end
    end

    // Load result capture: only an ack seen while requesting counts, so
    // stray or post-reset acks never disturb LoadData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data_q <= '0;
        end else if ((state == REQ) && DmemAck && is_load_q) begin
            load_data_q <= align_load;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-side outputs. Address, data and enables are
    // only driven during REQ and come from held registers, so they stay
    // stable for the whole request.
    always_comb begin
        state_next = state;
        DmemReq    = 1'b0;
        MemStall   = 1'b0;
        DmemWE     = 1'b0;
        DmemAddr   = '0;
        DmemWData  = '0;
        DmemByteEn = '0;

        case (state)
            IDLE, DONE: begin
                if (next_mem_op && !next_misaligned) begin
                    state_next = REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                DmemReq    = 1'b1;
                MemStall   = 1'b1;
                DmemWE     = mem_we_q;
                DmemAddr   = {alu_q[AW-1:2], 2'b00};
                DmemWData  = mem_we_q ? align_wdata : 32'h0;
                DmemByteEn = mem_we_q ? align_byte_en : 4'b1111;
                if (DmemAck) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Misalignment of the held instruction; the held address and size
    // are the values that were checked at the latch edge.
    assign Misaligned = mem_op_q & align_misaligned;
    assign RegWE      = reg_we_q & ~Misaligned;

    assign DInSrc     = din_src_q;
    assign RegWAddr   = reg_waddr_q;
    assign ALUOut     = alu_q;
    assign FPUOut     = fpu_q;
    assign PCPlusFour = pc4_q;
    assign LoadData   = load_data_q;

    // Forwarding mux. For a load it only becomes meaningful once the
    // access has completed.
    always_comb begin
        MemData = alu_q;
        case (din_src_q)
            DS_ALU:  MemData = alu_q;
            DS_MEM:  MemData = load_data_q;
            DS_PC4:  MemData = pc4_q;
            default: MemData = fpu_q;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] fpu;
        logic [31:0] regb;
        logic [31:0] pc4;
        logic [1:0]  src;
        logic        we;
        logic [5:0]  waddr;
        logic [1:0]  size;
        logic        memwe;
        logic        ext;
    } instr_t;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic        clk;
    logic        reset;
    logic [31:0] NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour;
    logic [1:0]  NextDInSrc;
    logic        NextRegWE;
    logic [5:0]  NextRegWAddr;
    logic [1:0]  NextMEMSize;
    logic        NextMEMWE;
    logic        NextExtMEM;
    logic        DmemReq, DmemWE;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemByteEn;
    logic        DmemAck;
    logic [31:0] DmemRData;
    logic        MemStall;
    logic [31:0] MemData;
    logic [1:0]  DInSrc;
    logic        RegWE;
    logic [5:0]  RegWAddr;
    logic [31:0] ALUOut, FPUOut, PCPlusFour, LoadData;
    logic        Misaligned;

    int n_checks;
    int n_fail;

    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic [31:0] seen_addr;
    logic        seen_we;
    logic [31:0] last_alu_in_req;
    logic [1:0]  last_src_in_req;
    int          req_cycles;
    int          stall_cycles;

    mem_stage #(.AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .NextALUOut     (NextALUOut),
        .NextFPUOut     (NextFPUOut),
        .NextRegB       (NextRegB),
        .NextPCPlusFour (NextPCPlusFour),
        .NextDInSrc     (NextDInSrc),
        .NextRegWE      (NextRegWE),
        .NextRegWAddr   (NextRegWAddr),
        .NextMEMSize    (NextMEMSize),
        .NextMEMWE      (NextMEMWE),
        .NextExtMEM     (NextExtMEM),
        .DmemReq        (DmemReq),
        .DmemWE         (DmemWE),
        .DmemAddr       (DmemAddr),
        .DmemWData      (DmemWData),
        .DmemByteEn     (DmemByteEn),
        .DmemAck        (DmemAck),
        .DmemRData      (DmemRData),
        .MemStall       (MemStall),
        .MemData        (MemData),
        .DInSrc         (DInSrc),
        .RegWE          (RegWE),
        .RegWAddr       (RegWAddr),
        .ALUOut         (ALUOut),
        .FPUOut         (FPUOut),
        .PCPlusFour     (PCPlusFour),
        .LoadData       (LoadData),
        .Misaligned     (Misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] regb,
                                  input logic [31:0] pc4, input logic [1:0] src,
                                  input logic we, input logic [1:0] size,
                                  input logic memwe, input logic ext);
        instr_t t;
        t.alu   = alu;
        t.fpu   = 32'h0F0F_0F0F;
        t.regb  = regb;
        t.pc4   = pc4;
        t.src   = src;
        t.we    = we;
        t.waddr = 6'd7;
        t.size  = size;
        t.memwe = memwe;
        t.ext   = ext;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        NextALUOut     = t.alu;
        NextFPUOut     = t.fpu;
        NextRegB       = t.regb;
        NextPCPlusFour = t.pc4;
        NextDInSrc     = t.src;
        NextRegWE      = t.we;
        NextRegWAddr   = t.waddr;
        NextMEMSize    = t.size;
        NextMEMWE      = t.memwe;
        NextExtMEM     = t.ext;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents op, lets it latch, then follows the request with 'follow'
    // on the inputs; the ack is raised from REQ cycle ack_delay+1 on.
    task automatic run_access(input instr_t op, input instr_t follow, input int ack_delay);
        drive(op);
        req_cycles   = 0;
        stall_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (MemStall) stall_cycles++;
            if (!DmemReq) break;
            req_cycles++;
            if (req_cycles == 1) begin
                seen_be    = DmemByteEn;
                seen_wdata = DmemWData;
                seen_addr  = DmemAddr;
                seen_we    = DmemWE;
                drive(follow);
            end
            last_alu_in_req = ALUOut;
            last_src_in_req = DInSrc;
            DmemAck = (req_cycles > ack_delay);
        end
        DmemAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        DmemAck = 1'b0;
        DmemRData = 32'h0;
        drive(mk(32'h0, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b0, 1'b0));
        step();
        step();
        n_checks++; if (DmemReq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", DmemReq); end
        n_checks++; if (MemStall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", MemStall); end
        n_checks++; if (Misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mis: got %b expected 0", Misaligned); end
        n_checks++; if ({MemData, LoadData, ALUOut} !== 96'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", {MemData, LoadData, ALUOut}); end
        n_checks++; if (DmemByteEn !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_be: got %b expected 0000", DmemByteEn); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_word_store();
        instr_t nop;
        nop = mk(32'h0, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b0, 1'b0);
        run_access(mk(32'h100, 32'hDEADBEEF, 32'h0, SRC_ALU, 1'b0, SZ_WORD, 1'b1, 1'b0), nop, 2);
        n_checks++; if (req_cycles !== 3) begin n_fail++; $display("[TB] FAIL ws_req_cycles: got %0d expected 3", req_cycles); end
        n_checks++; if (stall_cycles !== 3) begin n_fail++; $display("[TB] FAIL ws_stall_cycles: got %0d expected 3", stall_cycles); end
        n_checks++; if (seen_be !== 4'b1111) begin n_fail++; $display("[TB] FAIL ws_be: got %b expected 1111", seen_be); end
        n_checks++; if (seen_wdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL ws_wdata: got %h expected deadbeef", seen_wdata); end
        n_checks++; if ({seen_we, seen_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("[TB] FAIL ws_we_addr: got %b/%h expected 1/00000100", seen_we, seen_addr); end
        n_checks++; if (RegWE !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_regwe: got %b expected 0", RegWE); end
    endtask

    task automatic test_byte_load();
        instr_t nop;
        nop = mk(32'h0, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b0, 1'b0);
        DmemRData = 32'h112233F4;
        run_access(mk(32'h103, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_BYTE, 1'b0, 1'b1), nop, 0);
        n_checks++; if (req_cycles !== 1) begin n_fail++; $display("[TB] FAIL bl_req_cycles: got %0d expected 1", req_cycles); end
        n_checks++; if ({seen_we, seen_be, seen_addr} !== {1'b0, 4'b1111, 32'h100}) begin n_fail++; $display("[TB] FAIL bl_req_side: got %b/%b/%h expected 0/1111/00000100", seen_we, seen_be, seen_addr); end
        n_checks++; if (LoadData !== 32'hFFFFFFF4) begin n_fail++; $display("[TB] FAIL bl_sext: got %h expected fffffff4", LoadData); end
        n_checks++; if (MemData !== 32'hFFFFFFF4) begin n_fail++; $display("[TB] FAIL bl_memdata: got %h expected fffffff4", MemData); end
        n_checks++; if (RegWE !== 1'b1) begin n_fail++; $display("[TB] FAIL bl_regwe: got %b expected 1", RegWE); end
        run_access(mk(32'h103, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_BYTE, 1'b0, 1'b0), nop, 0);
        n_checks++; if (LoadData !== 32'h000000F4) begin n_fail++; $display("[TB] FAIL bl_zext: got %h expected 000000f4", LoadData); end
        DmemRData = 32'h5566_7788;
        run_access(mk(32'h101, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_BYTE, 1'b0, 1'b1), nop, 0);
        n_checks++; if (LoadData !== 32'h00000066) begin n_fail++; $display("[TB] FAIL bl_lane1: got %h expected 00000066", LoadData); end
    endtask

    task automatic test_half();
        instr_t nop;
        nop = mk(32'h0, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b0, 1'b0);
        DmemRData = 32'hAAAA8001;
        run_access(mk(32'h102, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_HALF, 1'b0, 1'b1), nop, 0);
        n_checks++; if (LoadData !== 32'hFFFF8001) begin n_fail++; $display("[TB] FAIL hl_low: got %h expected ffff8001", LoadData); end
        run_access(mk(32'h100, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_HALF, 1'b0, 1'b0), nop, 1);
        n_checks++; if (LoadData !== 32'h0000AAAA) begin n_fail++; $display("[TB] FAIL hl_high_zext: got %h expected 0000aaaa", LoadData); end
        run_access(mk(32'h102, 32'h0000_1234, 32'h0, SRC_ALU, 1'b0, SZ_HALF, 1'b1, 1'b0), nop, 0);
        n_checks++; if (seen_wdata !== 32'h12341234) begin n_fail++; $display("[TB] FAIL hs_wdata: got %h expected 12341234", seen_wdata); end
        n_checks++; if (seen_be !== 4'b0011) begin n_fail++; $display("[TB] FAIL hs_be: got %b expected 0011", seen_be); end
        run_access(mk(32'h101, 32'h0000_00A5, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b1, 1'b0), nop, 0);
        n_checks++; if ({seen_wdata, seen_be} !== {32'hA5A5A5A5, 4'b0100}) begin n_fail++; $display("[TB] FAIL bs_lane1: got %h/%b expected a5a5a5a5/0100", seen_wdata, seen_be); end
    endtask

    task automatic test_misaligned();
        drive(mk(32'h102, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_WORD, 1'b0, 1'b0));
        step();
        n_checks++; if ({DmemReq, MemStall} !== 2'b00) begin n_fail++; $display("[TB] FAIL mw_no_req: got %b expected 00", {DmemReq, MemStall}); end
        n_checks++; if (Misaligned !== 1'b1) begin n_fail++; $display("[TB] FAIL mw_flag: got %b expected 1", Misaligned); end
        n_checks++; if (RegWE !== 1'b0) begin n_fail++; $display("[TB] FAIL mw_regwe: got %b expected 0", RegWE); end
        drive(mk(32'h103, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_HALF, 1'b1, 1'b0));
        step();
        n_checks++; if ({DmemReq, Misaligned} !== 2'b01) begin n_fail++; $display("[TB] FAIL mh_store: got %b expected 01", {DmemReq, Misaligned}); end
        drive(mk(32'h103, 32'h0, 32'h0, SRC_ALU, 1'b1, SZ_WORD, 1'b0, 1'b0));
        step();
        n_checks++; if ({Misaligned, RegWE} !== 2'b01) begin n_fail++; $display("[TB] FAIL alu_not_mis: got %b expected 01", {Misaligned, RegWE}); end
    endtask

    task automatic test_back_to_back();
        drive(mk(32'h1111_0000, 32'h0, 32'h0, SRC_ALU, 1'b1, SZ_WORD, 1'b0, 1'b0));
        step();
        n_checks++; if (MemData !== 32'h11110000) begin n_fail++; $display("[TB] FAIL b2b_alu: got %h expected 11110000", MemData); end
        DmemRData = 32'hCAFEF00D;
        run_access(mk(32'h200, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_WORD, 1'b0, 1'b0),
                   mk(32'h999, 32'h0, 32'h0040_0008, SRC_PC4, 1'b1, SZ_WORD, 1'b0, 1'b0), 1);
        n_checks++; if (req_cycles !== 2) begin n_fail++; $display("[TB] FAIL b2b_req_cycles: got %0d expected 2", req_cycles); end
        n_checks++; if ({last_alu_in_req, last_src_in_req} !== {32'h200, SRC_MEM}) begin n_fail++; $display("[TB] FAIL b2b_hold: got %h/%b expected 00000200/01", last_alu_in_req, last_src_in_req); end
        n_checks++; if (MemData !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL b2b_load: got %h expected cafef00d", MemData); end
        step();
        n_checks++; if ({MemData, DInSrc} !== {32'h00400008, SRC_PC4}) begin n_fail++; $display("[TB] FAIL b2b_pc4: got %h/%b expected 00400008/10", MemData, DInSrc); end
    endtask

    task automatic test_reset_mid_access();
        drive(mk(32'h300, 32'h0, 32'h0, SRC_MEM, 1'b1, SZ_WORD, 1'b0, 1'b0));
        DmemRData = 32'h7777_7777;
        step();
        n_checks++; if (DmemReq !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_in_req: got %b expected 1", DmemReq); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({DmemReq, MemStall, DmemByteEn} !== 6'b0) begin n_fail++; $display("[TB] FAIL rm_drop: got %b expected 000000", {DmemReq, MemStall, DmemByteEn}); end
        n_checks++; if ({ALUOut, MemData} !== 64'h0) begin n_fail++; $display("[TB] FAIL rm_regs: got %h expected 0", {ALUOut, MemData}); end
        drive(mk(32'h0, 32'h0, 32'h0, SRC_ALU, 1'b0, SZ_BYTE, 1'b0, 1'b0));
        step();
        reset = 1'b0;
        DmemAck = 1'b1;
        step();
        step();
        n_checks++; if ({DmemReq, MemStall, LoadData} !== 34'h0) begin n_fail++; $display("[TB] FAIL rm_late_ack: got %h expected 0", {DmemReq, MemStall, LoadData}); end
        DmemAck = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-stage results and control on each clock edge.
- Performs data-memory loads and stores through a req/ack handshake with big-endian byte-lane alignment and sign/zero extension.
- Drives writeback control and data, and the MemData forwarding bus back to execute. Asserts MemStall to freeze the pipeline while an access is outstanding.

Parameters:
- AW, 32, data-memory address width (DmemAddr width).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- NextALUOut  in  32  execute ALU result; also the memory byte address
- NextFPUOut  in  32  execute FPU result
- NextRegB  in  32  store data
- NextPCPlusFour  in  32  link value
- NextDInSrc  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 FPU
- NextRegWE  in  1  register write enable
- NextRegWAddr  in  6  destination register
- NextMEMSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- NextMEMWE  in  1  store
- NextExtMEM  in  1  1 = sign-extend loads, 0 = zero-extend
- DmemReq  out  1  access request
- DmemWE  out  1  write strobe (valid with DmemReq)
- DmemAddr  out  AW  word-aligned address: ALUOut with bits [30:31] forced to 00
- DmemWData  out  32  lane-replicated store data
- DmemByteEn  out  4  lane enables; bit 0 = bits [0:7]
- DmemAck  in  1  access complete; DmemRData valid this cycle
- DmemRData  in  32  read word
- MemStall  out  1  hold the pipeline
- MemData  out  32  forwarding value: result selected by DInSrc
- DInSrc, RegWE, RegWAddr  out  2/1/6  registered control passed to writeback; RegWE is gated
- ALUOut, FPUOut, PCPlusFour, LoadData  out  32 each  writeback operands
- Misaligned  out  1  current instruction had a misaligned access

Behaviour:
- **Reset:**
  - All pipeline registers and outputs are 0; state is IDLE; MemStall, DmemReq and Misaligned are 0.
  - Reset asserted mid-access drops DmemReq immediately. A late DmemAck is ignored.
- **Pipeline register:**
  - Loads all Next* inputs on posedge clk when MemStall = 0.
  - Holds when MemStall = 1. Upstream stages must hold too, since MemStall is their stall.
- **Memory op:** NextMEMWE = 1 (store) or NextDInSrc = 01 (load).
- **Misaligned:** half with addr[31] = 1, or word with addr[30:31] ≠ 00.
  - Evaluated at the latch edge.
  - A misaligned op issues no access and sets Misaligned = 1 for that instruction.
  - RegWE output is forced to 0 for that instruction.
- **FSM states:** IDLE, REQ, DONE.
  - At a latch edge: an aligned memory op goes to REQ; otherwise IDLE.
  - **REQ:**
    - DmemReq = 1 and MemStall = 1.
    - DmemWE = store flag.
    - Address, data and byte enables are held stable.
  - **REQ with DmemAck = 1:**
    - For a load, capture the extracted and extended DmemRData into the LoadData register.
    - Go to DONE.
  - **DONE:**
    - DmemReq = 0 and MemStall = 0.
    - The next edge latches the next instruction and re-evaluates IDLE or REQ.
  - **IDLE:** MemStall = 0, DmemReq = 0.
  - An ack already present in the first REQ cycle gives a minimum of 2 cycles in-stage per memory op.
  - DmemAck outside REQ is ignored.
- **Store lanes (big-endian):**
  - byte: WData = {4{RegB[24:31]}}, ByteEn = one-hot at addr[30:31] (00 → 1000).
  - half: WData = {2{RegB[16:31]}}, ByteEn = 1100 if addr[30] = 0, else 0011.
  - word: WData = RegB, ByteEn = 1111.
  - Loads drive ByteEn = 1111.
- **Load extract:**
  - byte: lane selected by addr[30:31].
  - half: bits [0:15] if addr[30] = 0, else bits [16:31].
  - The extracted value is placed right-justified and extended per ExtMEM.
- **MemData** = mux(DInSrc: ALUOut, LoadData, PCPlusFour, FPUOut) of the registered values. It is not valid for a load while MemStall = 1.

Decomposition:
- **Shared package:**
  - MEMSize codes (MS_BYTE, MS_HALF, MS_WORD).
  - DInSrc codes (DS_ALU, DS_MEM, DS_PC4, DS_FPU).
  - FSM state encoding.
- **Sub-module mem_align (combinational):**
  - Inputs: addr[30:31], size, ext, store data, read word.
  - Outputs: WData, ByteEn, extracted load value, misaligned flag.
- mem_stage contains the pipeline register, the FSM, and the muxes.

Test Plan:
- **Word store:** ALUOut = 0x100, RegB = 0xDEADBEEF, MEMWE = 1, ack after 2 cycles.
  - DmemReq high 3 cycles, ByteEn = 1111, WData = 0xDEADBEEF, MemStall high 3 cycles, RegWE = 0.
- **Byte load, sign-extend:** addr 0x103, ExtMEM = 1, DmemRData = 0x112233F4, immediate ack.
  - LoadData = MemData = 0xFFFFFFF4. Same with ExtMEM = 0 → 0x000000F4.
- **Half load:** addr 0x102, RData = 0xAAAA8001, ExtMEM = 1.
  - LoadData = 0xFFFF8001. Half store of 0x1234 at 0x102 → WData = 0x12341234, ByteEn = 0011.
- **Misaligned word load:** addr 0x102.
  - No DmemReq, Misaligned = 1, RegWE = 0, MemStall = 0.
- **Back-to-back:** ALU op (DInSrc = 00), then load, then PC+4 op.
  - MemData shows ALUOut, then LoadData after ack, then PCPlusFour.
  - The instruction after the load is held (not latched) while MemStall = 1.
- **Reset mid-access:** assert reset in REQ.
  - DmemReq = 0 immediately, state IDLE, outputs 0. A later DmemAck has no effect.
